// File: rtl/net_pkg.sv
// Shared definitions for the CRC network frame path: line-format constants,
// header field positions and the medium arbiter state encoding.
package net_pkg;

  // Line format: preamble, start-of-frame delimiter, header, payload, CRC-8.
  localparam logic [15:0] PREAMBLE_PATTERN = 16'hAAAA;
  localparam logic [7:0]  SFD_PATTERN      = 8'hAB;

  // Header byte layout {dest[1:0], src[1:0], length[3:0]}.
  localparam int HDR_DEST_MSB = 7;
  localparam int HDR_DEST_LSB = 6;
  localparam int HDR_SRC_MSB  = 5;
  localparam int HDR_SRC_LSB  = 4;
  localparam int HDR_LEN_MSB  = 3;
  localparam int HDR_LEN_LSB  = 0;

  // Longest frame on the wire: 16 + 8 + 8 + 16*8 + 8 bits.
  localparam int MAX_FRAME_BITS = 168;

  // Medium arbiter FSM states.
  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_LAUNCH    = 2'd1,
    ARB_WAIT_DONE = 2'd2,
    ARB_GAP       = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick4.sv
// Four-way round-robin picker: the first set request bit found scanning
// upward from ptr, wrapping 3 -> 0. Purely combinational.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] winner,
  output logic [1:0] idx
);

  logic       found;
  logic [1:0] cand;

  // Scan the four positions starting at ptr; the first hit wins.
  always_comb begin
    winner = 4'b0000;
    idx    = 2'd0;
    found  = 1'b0;
    cand   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && req[cand]) begin
        found  = 1'b1;
        idx    = cand;
        winner = 4'b0001 << cand;
      end
    end
  end

endmodule

// File: rtl/tx_medium_arbiter.sv
// Round-robin scheduler sharing one serial frame transmitter among four
// local requesters. Picks a winner, loads the header/payload registers,
// pulses tx_start, waits for tx_done or a watchdog timeout, acknowledges
// the winner and then holds off arbitration for an inter-frame gap.
//
// Handshakes: a requester holds req[i] high with its fields stable until it
// sees the one-cycle ack[i] pulse (ack_err qualifies that pulse). Towards the
// transmitter, tx_start is a one-cycle launch with tx_* already stable, and
// tx_done is a one-cycle completion pulse that only counts in WAIT_DONE.
module tx_medium_arbiter
  import net_pkg::*;
#(
  parameter int IFG_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [7:0]   req_dest,
  input  logic [15:0]  req_len,
  input  logic [511:0] req_payload,
  output logic         tx_start,
  output logic [1:0]   tx_dest_id,
  output logic [1:0]   tx_src_id,
  output logic [3:0]   tx_length,
  output logic [127:0] tx_payload,
  input  logic         tx_done,
  output logic [3:0]   grant,
  output logic [3:0]   ack,
  output logic         ack_err,
  output logic         busy,
  output logic [1:0]   state_dbg
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam int GAP_W = $clog2(IFG_CYCLES + 1);

  // The counter is compared one below its "reaches TIMEOUT-1" value so the
  // registered ack lands exactly TIMEOUT_CYCLES cycles after LAUNCH.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 2);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IFG_CYCLES - 1);

  arb_state_t       state_q, state_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [1:0]       win_idx_q, win_idx_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [3:0]       grant_q, grant_d;
  logic [3:0]       ack_q, ack_d;
  logic             ack_err_q, ack_err_d;
  logic             busy_q, busy_d;
  logic             tx_start_q, tx_start_d;
  logic [1:0]       tx_dest_q, tx_dest_d;
  logic [1:0]       tx_src_q, tx_src_d;
  logic [3:0]       tx_len_q, tx_len_d;
  logic [127:0]     tx_pay_q, tx_pay_d;

  logic [3:0]       pick_onehot;
  logic [1:0]       pick_idx;

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (rr_ptr_q),
    .winner (pick_onehot),
    .idx    (pick_idx)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    win_idx_d  = win_idx_q;
    tmo_d      = tmo_q;
    gap_d      = gap_q;
    grant_d    = grant_q;
    ack_d      = 4'b0000;
    ack_err_d  = 1'b0;
    tx_start_d = 1'b0;
    tx_dest_d  = tx_dest_q;
    tx_src_d   = tx_src_q;
    tx_len_d   = tx_len_q;
    tx_pay_d   = tx_pay_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (req != 4'b0000) begin
          win_idx_d  = pick_idx;
          grant_d    = pick_onehot;
          tx_src_d   = pick_idx;
          tx_dest_d  = req_dest[{pick_idx, 1'b0} +: 2];
          tx_len_d   = req_len[{pick_idx, 2'b00} +: 4];
          tx_pay_d   = req_payload[{pick_idx, 7'd0} +: 128];
          tx_start_d = 1'b1;
          state_d    = ARB_LAUNCH;
        end
      end
      ARB_LAUNCH: begin
        tmo_d   = '0;
        state_d = ARB_WAIT_DONE;
      end
      ARB_WAIT_DONE: begin
        tmo_d = tmo_q + 1'b1;
        // tx_done takes precedence over a timeout in the same cycle.
        if (tx_done || (tmo_q == TMO_LAST)) begin
          ack_d     = grant_q;
          ack_err_d = ~tx_done;
          grant_d   = 4'b0000;
          rr_ptr_d  = win_idx_q + 2'd1;
          gap_d     = GAP_LOAD;
          state_d   = ARB_GAP;
        end
      end
      ARB_GAP: begin
        if (gap_q == '0) begin
          state_d = ARB_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    busy_d = (state_d != ARB_IDLE);
  end

  // State, pointer, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= 2'd0;
      win_idx_q  <= 2'd0;
      tmo_q      <= '0;
      gap_q      <= '0;
      grant_q    <= 4'b0000;
      ack_q      <= 4'b0000;
      ack_err_q  <= 1'b0;
      busy_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_dest_q  <= 2'd0;
      tx_src_q   <= 2'd0;
      tx_len_q   <= 4'd0;
      tx_pay_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      win_idx_q  <= win_idx_d;
      tmo_q      <= tmo_d;
      gap_q      <= gap_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      ack_err_q  <= ack_err_d;
      busy_q     <= busy_d;
      tx_start_q <= tx_start_d;
      tx_dest_q  <= tx_dest_d;
      tx_src_q   <= tx_src_d;
      tx_len_q   <= tx_len_d;
      tx_pay_q   <= tx_pay_d;
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_dest_id = tx_dest_q;
  assign tx_src_id  = tx_src_q;
  assign tx_length  = tx_len_q;
  assign tx_payload = tx_pay_q;
  assign grant      = grant_q;
  assign ack        = ack_q;
  assign ack_err    = ack_err_q;
  assign busy       = busy_q;
  assign state_dbg  = state_q;

endmodule
